// File: rtl/vector_resp_arbiter.sv
// Round-robin response scheduler: picks one ready FIFO lane per cycle, moves its
// head entry into a single-entry output register and presents it on heard.
module vector_resp_arbiter #(
    parameter int LANES  = 11,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 4
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [LANES-1:0]        lane_first__RDY,
    input  logic [LANES-1:0]        lane_deq__RDY,
    input  logic [LANES*DATA_W-1:0] lane_first_meth,
    input  logic [LANES*DATA_W-1:0] lane_first_v,
    output logic [LANES-1:0]        lane_deq__ENA,
    output logic                    heard__ENA,
    output logic [DATA_W-1:0]       heard_meth,
    output logic [DATA_W-1:0]       heard_v,
    output logic [IDX_W-1:0]        heard_lane,
    input  logic                    heard__RDY,
    input  logic                    mask_set__ENA,
    input  logic [LANES-1:0]        mask_set_v,
    output logic                    mask_set__RDY,
    output logic [31:0]             served_count
);

    logic              out_valid;
    logic [DATA_W-1:0] out_meth;
    logic [DATA_W-1:0] out_v;
    logic [IDX_W-1:0]  out_lane;
    logic [IDX_W-1:0]  ptr;
    logic [LANES-1:0]  mask;

    logic [LANES-1:0]  eligible;
    logic              fire_out;
    logic              can_load;
    logic              grant_valid;
    logic [IDX_W-1:0]  grant_idx;

    assign eligible      = lane_first__RDY & lane_deq__RDY & mask;
    // Gating with nRST keeps both strobes quiet while reset is being applied.
    assign fire_out      = out_valid & heard__RDY & nRST;
    assign can_load      = ~out_valid | fire_out;
    assign heard__ENA    = fire_out;
    assign heard_meth    = out_meth;
    assign heard_v       = out_v;
    assign heard_lane    = out_lane;
    assign mask_set__RDY = nRST;

    // Round-robin scan starting just after the last granted lane, wrapping at LANES.
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= LANES; k++) begin
            idx = (int'(ptr) + k) % LANES;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = idx[IDX_W-1:0];
            end
        end
        if (!(can_load && nRST)) begin
            grant_valid = 1'b0;
        end
    end

    // One-hot dequeue strobe for the granted lane.
    always_comb begin
        lane_deq__ENA = '0;
        if (grant_valid) begin
            lane_deq__ENA[grant_idx] = 1'b1;
        end
    end

    // Output register, round-robin pointer, lane mask and delivery counter.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            out_valid    <= 1'b0;
            out_meth     <= '0;
            out_v        <= '0;
            out_lane     <= '0;
            ptr          <= IDX_W'(LANES - 1);
            mask         <= '1;
            served_count <= 32'd0;
        end else begin
            if (mask_set__ENA) begin
                mask <= mask_set_v;
            end
            if (fire_out) begin
                served_count <= served_count + 32'd1;
            end
            if (grant_valid) begin
                out_valid <= 1'b1;
                out_meth  <= lane_first_meth[int'(grant_idx)*DATA_W +: DATA_W];
                out_v     <= lane_first_v[int'(grant_idx)*DATA_W +: DATA_W];
                out_lane  <= grant_idx;
                ptr       <= grant_idx;
            end else if (fire_out) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vector_resp_arbiter.sv
// Directed bench for vector_resp_arbiter with a scoreboard queue of expected deliveries.
module tb_vector_resp_arbiter;

    localparam int LANES  = 11;
    localparam int DATA_W = 32;
    localparam int IDX_W  = 4;

    logic                    CLK;
    logic                    nRST;
    logic [LANES-1:0]        lane_first__RDY;
    logic [LANES-1:0]        lane_deq__RDY;
    logic [LANES*DATA_W-1:0] lane_first_meth;
    logic [LANES*DATA_W-1:0] lane_first_v;
    logic [LANES-1:0]        lane_deq__ENA;
    logic                    heard__ENA;
    logic [DATA_W-1:0]       heard_meth;
    logic [DATA_W-1:0]       heard_v;
    logic [IDX_W-1:0]        heard_lane;
    logic                    heard__RDY;
    logic                    mask_set__ENA;
    logic [LANES-1:0]        mask_set_v;
    logic                    mask_set__RDY;
    logic [31:0]             served_count;

    typedef struct {
        int          lane;
        logic [31:0] meth;
        logic [31:0] v;
    } entry_t;

    entry_t exp_q[$];
    int     vectors;
    int     miscompares;

    vector_resp_arbiter #(
        .LANES (LANES),
        .DATA_W(DATA_W),
        .IDX_W (IDX_W)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .lane_first__RDY(lane_first__RDY),
        .lane_deq__RDY  (lane_deq__RDY),
        .lane_first_meth(lane_first_meth),
        .lane_first_v   (lane_first_v),
        .lane_deq__ENA  (lane_deq__ENA),
        .heard__ENA     (heard__ENA),
        .heard_meth     (heard_meth),
        .heard_v        (heard_v),
        .heard_lane     (heard_lane),
        .heard__RDY     (heard__RDY),
        .mask_set__ENA  (mask_set__ENA),
        .mask_set_v     (mask_set_v),
        .mask_set__RDY  (mask_set__RDY),
        .served_count   (served_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Fixed head contents: lane 5 carries 0x12 / 0xABCD, others 0x100+i / 0xA000+i.
    function automatic logic [31:0] head_meth(int i);
        return (i == 5) ? 32'h12 : 32'h100 + 32'(i);
    endfunction

    function automatic logic [31:0] head_v(int i);
        return (i == 5) ? 32'hABCD : 32'hA000 + 32'(i);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic push(input int lane);
        entry_t e;
        e.lane = lane;
        e.meth = head_meth(lane);
        e.v    = head_v(lane);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lanes(input logic [LANES-1:0] first, input logic [LANES-1:0] deq);
        lane_first__RDY = first;
        lane_deq__RDY   = deq;
    endtask

    // Monitor: every delivered entry must match the head of the scoreboard.
    always @(negedge CLK) begin
        if (heard__ENA === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fire", 32'(heard_lane), 32'hFFFF_FFFF);
            end else begin
                entry_t e;
                e = exp_q.pop_front();
                chk("heard_lane", 32'(heard_lane), 32'(e.lane));
                chk("heard_meth", heard_meth, e.meth);
                chk("heard_v", heard_v, e.v);
            end
        end
    end

    initial begin
        int deq_total;
        int seq3[3];
        vectors     = 0;
        miscompares = 0;
        seq3[0] = 0;
        seq3[1] = 3;
        seq3[2] = 7;
        for (int i = 0; i < LANES; i++) begin
            lane_first_meth[i*DATA_W +: DATA_W] = head_meth(i);
            lane_first_v[i*DATA_W +: DATA_W]    = head_v(i);
        end
        nRST          = 1'b0;
        heard__RDY    = 1'b0;
        mask_set__ENA = 1'b0;
        mask_set_v    = '0;
        set_lanes('0, '0);

        // Reset state
        @(negedge CLK);
        chk("rst_heard_ena", 32'(heard__ENA), 32'd0);
        chk("rst_deq_ena", 32'(lane_deq__ENA), 32'd0);
        chk("rst_mask_rdy", 32'(mask_set__RDY), 32'd0);
        chk("rst_served", served_count, 32'd0);
        tick();
        nRST = 1'b1;

        // Lanes 0, 3, 7 round robin
        set_lanes(11'h089, 11'h089);
        heard__RDY = 1'b1;
        for (int k = 0; k < 6; k++) push(seq3[k % 3]);
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                chk("mask_rdy", 32'(mask_set__RDY), 32'd1);
                chk("first_no_fire", 32'(heard__ENA), 32'd0);
            end
            chk("rr3_deq", 32'(lane_deq__ENA), 32'd1 << seq3[k % 3]);
            if (k == 4) chk("served_after3", served_count, 32'd3);
            tick();
        end
        set_lanes('0, '0);
        @(negedge CLK);
        tick();

        // Lane 5 under backpressure
        set_lanes(11'h020, 11'h020);
        heard__RDY = 1'b0;
        push(5);
        push(5);
        deq_total = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            deq_total += $countones(lane_deq__ENA);
            if (k == 0) begin
                chk("bp_first_deq", 32'(lane_deq__ENA), 32'h020);
            end else begin
                chk("bp_no_deq", 32'(lane_deq__ENA), 32'd0);
                chk("bp_no_fire", 32'(heard__ENA), 32'd0);
                chk("bp_meth", heard_meth, 32'h12);
                chk("bp_v", heard_v, 32'hABCD);
                chk("bp_lane", 32'(heard_lane), 32'd5);
            end
            tick();
        end
        chk("bp_deq_total", 32'(deq_total), 32'd1);
        heard__RDY = 1'b1;
        @(negedge CLK);
        chk("bp_release_fire", 32'(heard__ENA), 32'd1);
        chk("bp_refill_deq", 32'(lane_deq__ENA), 32'h020);
        tick();
        set_lanes('0, '0);
        @(negedge CLK);
        tick();
        @(negedge CLK);
        chk("served_after_bp", served_count, 32'd8);

        // Reset with nothing held, so the pointer starts over at lane 0
        tick();
        nRST = 1'b0;
        @(negedge CLK);
        tick();
        nRST = 1'b1;
        @(negedge CLK);
        chk("rst2_served", served_count, 32'd0);
        chk("rst2_no_fire", 32'(heard__ENA), 32'd0);
        tick();

        // All 11 lanes for 22 cycles
        set_lanes('1, '1);
        for (int k = 0; k < 22; k++) push(k % LANES);
        for (int k = 0; k < 22; k++) begin
            @(negedge CLK);
            chk("all_deq", 32'(lane_deq__ENA), 32'd1 << (k % LANES));
            tick();
        end
        set_lanes('0, '0);
        @(negedge CLK);
        tick();

        // Mask update: ptr goes to 1, then lanes 2/4 with mask set to 0x004
        push(1);
        for (int k = 0; k < 8; k++) push(2);
        for (int k = 0; k < 12; k++) begin
            logic [LANES-1:0] l;
            logic [LANES-1:0] e;
            mask_set__ENA = 1'b0;
            if (k == 0) begin
                l = 11'h002; e = 11'h002;
            end else if (k <= 5) begin
                l = 11'h014; e = 11'h004;
            end else if (k <= 8) begin
                l = 11'h7FF; e = 11'h004;
            end else if (k <= 10) begin
                l = 11'h7FF; e = 11'h000;
            end else begin
                l = 11'h000; e = 11'h000;
            end
            if (k == 1) begin
                mask_set__ENA = 1'b1; mask_set_v = 11'h004;
            end else if (k == 8) begin
                mask_set__ENA = 1'b1; mask_set_v = 11'h000;
            end else if (k == 11) begin
                mask_set__ENA = 1'b1; mask_set_v = 11'h7FF;
            end
            set_lanes(l, l);
            @(negedge CLK);
            chk("mask_deq", 32'(lane_deq__ENA), 32'(e));
            tick();
        end
        mask_set__ENA = 1'b0;

        // Lane 6 has a head but cannot dequeue; lane 8 is served instead
        set_lanes(11'h140, 11'h100);
        for (int k = 0; k < 3; k++) push(8);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("deq_rdy_gate", 32'(lane_deq__ENA), 32'h100);
            tick();
        end
        set_lanes('0, '0);
        @(negedge CLK);
        tick();

        // Reset while an entry is held: it is dropped and not counted
        set_lanes(11'h008, 11'h008);
        heard__RDY = 1'b0;
        @(negedge CLK);
        chk("hold_deq", 32'(lane_deq__ENA), 32'h008);
        tick();
        nRST = 1'b0;
        set_lanes('0, '0);
        @(negedge CLK);
        chk("midrst_deq", 32'(lane_deq__ENA), 32'd0);
        chk("midrst_fire", 32'(heard__ENA), 32'd0);
        chk("midrst_mask_rdy", 32'(mask_set__RDY), 32'd0);
        tick();
        nRST = 1'b1;
        heard__RDY = 1'b1;
        set_lanes(11'h009, 11'h009);
        push(0);
        @(negedge CLK);
        chk("postrst_fire", 32'(heard__ENA), 32'd0);
        chk("postrst_served", served_count, 32'd0);
        chk("postrst_deq", 32'(lane_deq__ENA), 32'h001);
        tick();
        set_lanes('0, '0);
        @(negedge CLK);
        tick();
        @(negedge CLK);
        chk("final_served", served_count, 32'd1);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vector_resp_arbiter.md
# vector_resp_arbiter

Round-robin response scheduler for the FIFO-vector indication path. It sits between the `out` ports of up to LANES FifoPong lanes and the single `ind$heard` indication interface. Each cycle it picks one ready lane fairly, dequeues its head entry into a one-entry output register, and presents that entry on `heard` under the ENA/RDY method handshake. This replaces the single hard-wired respond rule per vector.

## Interface

Parameters:
- LANES, 11, number of FIFO lanes arbitrated (2..16)
- DATA_W, 32, width of each of the meth and v fields
- IDX_W, 4, width of the lane index; must satisfy 2^IDX_W >= LANES

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- lane_first__RDY  in  LANES  head entry valid per lane
- lane_deq__RDY  in  LANES  lane can accept deq
- lane_first_meth  in  LANES*DATA_W  head meth per lane; lane i at bits [i*DATA_W +: DATA_W]
- lane_first_v  in  LANES*DATA_W  head v per lane; same packing as lane_first_meth
- lane_deq__ENA  out  LANES  one-hot dequeue strobe
- heard__ENA  out  1  indication fire
- heard_meth  out  DATA_W  registered meth
- heard_v  out  DATA_W  registered v
- heard_lane  out  IDX_W  source lane of presented entry
- heard__RDY  in  1  downstream ready
- mask_set__ENA  in  1  write lane enable mask
- mask_set_v  in  LANES  new mask value
- mask_set__RDY  out  1  always 1 when out of reset
- served_count  out  32  number of entries delivered, wraps mod 2^32

## Operation

- State: out_valid (1b), out_meth/out_v/out_lane regs, ptr (IDX_W, last granted lane), mask (LANES), served_count.
- eligible[i] = lane_first__RDY[i] & lane_deq__RDY[i] & mask[i].
- fire_out = out_valid & heard__RDY. heard__ENA = fire_out. heard_* reflect the output registers whenever out_valid = 1.
- can_load = !out_valid | fire_out. The output register is single-entry, pass-through-on-drain.
- Grant: when can_load and eligible != 0, grant the first eligible lane scanning ptr+1, ptr+2, …, wrapping modulo LANES. Index arithmetic wraps at LANES, not 2^IDX_W.
- On grant g:
  - lane_deq__ENA[g] = 1 that cycle, and no other bit is set.
  - The output registers load lane g's head meth/v; out_lane <= g.
  - ptr <= g.
  - out_valid <= 1.
- No grant with fire_out: out_valid <= 0.
- lane_deq__ENA is combinational and never asserted unless the matching lane_first__RDY and lane_deq__RDY are both 1.
- served_count increments by 1 on each fire_out.
- Mask:
  - mask_set__ENA writes mask <= mask_set_v, effective the next cycle.
  - A grant in the same cycle uses the old mask.
  - An entry already in the output register is delivered regardless of the mask.
  - Mask = 0 stalls new grants only.
- Reset values: out_valid 0; ptr LANES-1, so lane 0 wins first; mask all ones; served_count 0; out_meth, out_v and out_lane 0.
- Reset output values: heard__ENA 0; lane_deq__ENA 0; mask_set__RDY 0 during reset, 1 otherwise.
- Reset mid-operation: an entry held in the output register is discarded and is not counted. Lane FIFOs are not touched.

## Timing

- Latency: a lane dequeued in cycle N is presented in cycle N+1; heard__ENA asserts in N+1 if heard__RDY = 1.
- Throughput: 1 entry/cycle with heard__RDY held high and any lane eligible.
- Backpressure: with heard__RDY low and out_valid = 1, there is no dequeue, and heard_* and heard_lane hold stable.
- Drain + refill in the same cycle is legal. The fire and the new grant both occur, and the new data appears the next cycle.
- Fairness: a continuously eligible lane is granted within LANES grants.

## Test plan

- Reset, then lanes 0, 3 and 7 eligible, heard__RDY = 1 → grants 0, 3, 7, 0, …
  - lane_deq__ENA one-hot each cycle.
  - heard_lane sequence 0, 3, 7 starting one cycle after the first deq.
  - served_count = 3 after 3 fires.
- Lane 5 only, head meth = 0x12, v = 0xABCD, heard__RDY low for 4 cycles → exactly one deq.
  - heard_meth = 0x12 and heard_v = 0xABCD held stable.
  - On the RDY rise, heard__ENA fires once, and a second lane-5 deq happens in the same cycle.
- All 11 lanes eligible continuously for 22 cycles → each lane granted exactly twice, in order 0..10, 0..10 (checks wrap at LANES = 11).
- Set mask = 0x004 in the cycle lane 2 and lane 4 are eligible with ptr = 1 → this cycle grants lane 2 under the old mask. Afterwards only lane 2 is ever granted.
- Lane with lane_first__RDY = 1 but lane_deq__RDY = 0 → never granted and never strobed. Another eligible lane is served instead.
- Assert nRST = 0 for one cycle while out_valid = 1 → next cycle heard__ENA = 0, served_count = 0, and the first grant goes to lane 0.
